// File: rtl/branch_predictor_if.sv
// Fetch/EX-side signal bundle for branch_predictor.
// Stats ports exist only when BP_STATS_EN is defined.
interface branch_predictor_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] IF_pc;
  logic [1:0]          IF_prediction;
  logic                IF_predict_taken;
  logic                ready;
  logic                EX_Branch;
  logic [PC_WIDTH-1:0] EX_pc;
  logic [1:0]          prediction_status;
  logic                mispredict;
`ifdef BP_STATS_EN
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;
`endif

  modport master (
`ifdef BP_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    output IF_pc, EX_Branch, EX_pc, prediction_status,
    input  IF_prediction, IF_predict_taken, ready, mispredict
  );

  modport slave (
`ifdef BP_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    input  IF_pc, EX_Branch, EX_pc, prediction_status,
    output IF_prediction, IF_predict_taken, ready, mispredict
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter direction predictor with a reset-time init sweep.
// Optional BP_STATS_EN adds 32-bit branch / mispredict counters.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [1:0]            ctr_q [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx, ex_idx, wr_idx;
  logic [1:0]            ex_cur, ex_new, wr_val;
  logic                  taken, upd_en, wr_en, ready;

  assign if_idx = bp.IF_pc[INDEX_BITS+1:2];
  assign ex_idx = bp.EX_pc[INDEX_BITS+1:2];
  assign ex_cur = ctr_q[ex_idx];
  assign taken  = (bp.prediction_status == 2'd0) || (bp.prediction_status == 2'd3);

  always_comb begin
    ex_new = ex_cur;
    if (taken) begin
      if (ex_cur != 2'b11) ex_new = ex_cur + 2'd1;
    end else begin
      if (ex_cur != 2'b00) ex_new = ex_cur - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready   = 1'b0;
    upd_en  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_val  = 2'b01;
    case (state_q)
      S_INIT: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = S_RUN;
      end
      default: begin
        ready = 1'b1;
        if (bp.EX_Branch) begin
          upd_en = 1'b1;
          wr_en  = 1'b1;
          wr_idx = ex_idx;
          wr_val = ex_new;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Counter array is deliberately not reset; the init sweep rebuilds it.
  always_ff @(posedge clk) begin
    if (wr_en) ctr_q[wr_idx] <= wr_val;
  end

  // Write-first: a same-cycle update to the fetched index is forwarded.
  always_comb begin
    if (!ready)                            bp.IF_prediction = 2'b01;
    else if (upd_en && (ex_idx == if_idx)) bp.IF_prediction = ex_new;
    else                                   bp.IF_prediction = ctr_q[if_idx];
  end

  assign bp.IF_predict_taken = bp.IF_prediction[1];
  assign bp.ready            = ready;
  assign bp.mispredict       = bp.EX_Branch && ready && (bp.prediction_status <= 2'd1);

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (state_q == S_RUN) begin
      if (bp.EX_Branch)  stat_br_q  <= stat_br_q + 32'd1;
      if (bp.mispredict) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mis_q;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.IF_pc, bp.EX_pc};
endmodule
